// File: rtl/alu_mc_if.sv
// alu_mc request/result bundle.
// The master issues requests; the slave returns results and flags.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             I_enable;
  logic             I_valid;
  logic             O_ready;
  logic [3:0]       I_opcode;
  logic             I_signed;
  logic             I_use_imm;
  logic [7:0]       I_immediate;
  logic [WIDTH-1:0] I_rA;
  logic [WIDTH-1:0] I_rB;
  logic             O_valid;
  logic [WIDTH-1:0] O_out;
  logic [WIDTH-1:0] O_out_hi;
  logic [3:0]       O_flags;
  logic             O_div_zero;
  logic             O_illegal;

  modport master (
    output I_enable, I_valid, I_opcode,
    output I_signed, I_use_imm, I_immediate,
    output I_rA, I_rB,
    input  O_ready, O_valid, O_out, O_out_hi,
    input  O_flags, O_div_zero, O_illegal
  );

  modport slave (
    input  I_enable, I_valid, I_opcode,
    input  I_signed, I_use_imm, I_immediate,
    input  I_rA, I_rB,
    output O_ready, O_valid, O_out, O_out_hi,
    output O_flags, O_div_zero, O_illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus
// bit-serial MUL (shift-add) and DIV (restoring).
module alu_mc #(
  parameter int WIDTH = 16
) (
  input logic     I_clk,
  input logic     I_reset_n,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef enum logic [1:0] {
    IDLE, MUL, DIV
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] outh_q, outh_d;
  logic [3:0]       flags_q, flags_d;
  logic             dz_q, dz_d;
  logic             il_q, il_d;

  logic [WIDTH-1:0]   a, b, abs_a, abs_b;
  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     wide, mul_sum;
  logic [WIDTH:0]     rem_w, rem_n;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_c, res_v;
  logic               fire, dz, il;

  assign bus.O_ready    = (state_q == IDLE) & I_reset_n;
  assign bus.O_valid    = valid_q;
  assign bus.O_out      = out_q;
  assign bus.O_out_hi   = outh_q;
  assign bus.O_flags    = flags_q;
  assign bus.O_div_zero = dz_q;
  assign bus.O_illegal  = il_q;

  // Operand selection and one serial MUL/DIV step
  always_comb begin
    a = bus.I_rA;
    b = bus.I_rB;
    if (bus.I_use_imm) begin
      if (bus.I_signed) b = WIDTH'($signed(bus.I_immediate));
      else              b = WIDTH'(bus.I_immediate);
    end
    abs_a = (bus.I_signed && a[WIDTH-1]) ? -a : a;
    abs_b = (bus.I_signed && b[WIDTH-1]) ? -b : b;
    amt = b[SHW-1:0];
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    rem_w = {hi_q, lo_q[WIDTH-1]};
    div_ge = rem_w >= {1'b0, m_q};
    rem_n = div_ge ? rem_w - {1'b0, m_q} : rem_w;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    out_d   = out_q;
    outh_d  = outh_q;
    flags_d = flags_q;
    dz_d    = dz_q;
    il_d    = il_q;
    wide    = '0;
    prod    = '0;
    res_lo  = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    fire    = 1'b0;
    dz      = 1'b0;
    il      = 1'b0;
    if (bus.I_enable) begin
      unique case (state_q)
        IDLE: if (bus.I_valid) begin
          fire = 1'b1;
          case (bus.I_opcode)
            OP_ADD: begin
              {res_c, res_lo} = {1'b0, a} + {1'b0, b};
              res_v = (a[WIDTH-1] == b[WIDTH-1])
                   && (res_lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
              {res_c, res_lo} = {1'b0, a} - {1'b0, b};
              res_v = (a[WIDTH-1] != b[WIDTH-1])
                   && (res_lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_lo = a & b;
            OP_OR:  res_lo = a | b;
            OP_XOR: res_lo = a ^ b;
            OP_NOT: res_lo = ~a;
            OP_SHL: begin
              wide   = {1'b0, a} << amt;
              res_lo = wide[WIDTH-1:0];
              res_c  = wide[WIDTH];
            end
            OP_SHR: begin
              // extra low bit catches the last bit shifted out
              if (bus.I_signed) wide = $signed({a, 1'b0}) >>> amt;
              else              wide = {a, 1'b0} >> amt;
              res_lo = wide[WIDTH:1];
              res_c  = wide[0];
            end
            OP_MUL: begin
              fire    = 1'b0;
              state_d = MUL;
              cnt_d   = '0;
              m_d     = abs_a;
              lo_d    = abs_b;
              hi_d    = '0;
              sgn_d   = bus.I_signed;
              negq_d  = bus.I_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            OP_DIV: if (b == '0) begin
              res_lo = '1;
              res_hi = a;
              dz     = 1'b1;
            end else begin
              fire    = 1'b0;
              state_d = DIV;
              cnt_d   = '0;
              m_d     = abs_b;
              lo_d    = abs_a;
              hi_d    = '0;
              negq_d  = bus.I_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              negr_d  = bus.I_signed & a[WIDTH-1];
              ovf_d   = bus.I_signed && (&b)
                     && (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: il = 1'b1;
          endcase
        end
        MUL: begin
          hi_d  = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            fire    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            prod    = {hi_d, lo_d};
            if (negq_q) prod = -prod;
            res_lo = prod[WIDTH-1:0];
            res_hi = prod[2*WIDTH-1:WIDTH];
            if (sgn_q) res_c = res_hi != {WIDTH{res_lo[WIDTH-1]}};
            else       res_c = |res_hi;
            res_v = res_c;
          end
        end
        DIV: begin
          hi_d  = rem_n[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            fire    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            res_lo  = negq_q ? -lo_d : lo_d;
            res_hi  = negr_q ? -hi_d : hi_d;
            res_v   = ovf_q;
          end
        end
        default: state_d = IDLE;
      endcase
      valid_d = fire;
      dz_d    = dz;
      il_d    = il;
      if (fire) begin
        out_d   = res_lo;
        outh_d  = res_hi;
        flags_d = {~|res_lo, res_lo[WIDTH-1], res_c, res_v};
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
      outh_q  <= '0;
      flags_q <= '0;
      dz_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      outh_q  <= outh_d;
      flags_q <= flags_d;
      dz_q    <= dz_d;
      il_q    <= il_d;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: arithmetic reference model,
// directed corner cases and randomized back-to-back traffic.
module tb_alu_mc;
  localparam int W = 16;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (
    .I_clk    (clk),
    .I_reset_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic [15:0] hi;
    logic [3:0]  flags;
    logic        dz;
    logic        il;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int passed = 0;
  int pops = 0;
  int pop_cyc = 0;
  int acc_edge = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic s,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    int sa, sb_, ua, ub, amt, r;
    longint p;
    logic c, v;
    e.out = '0; e.hi = '0; e.dz = 1'b0; e.il = 1'b0;
    c = 1'b0; v = 1'b0;
    sa = int'($signed(a)); sb_ = int'($signed(b));
    ua = int'(a); ub = int'(b);
    amt = ub % 16;
    case (op)
      4'd0: begin
        r = ua + ub; e.out = r[15:0]; c = r > 65535;
        v = (sa + sb_ > 32767) || (sa + sb_ < -32768);
      end
      4'd1, 4'd10: begin
        e.out = 16'(ua - ub); c = ua < ub;
        v = (sa - sb_ > 32767) || (sa - sb_ < -32768);
      end
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a ^ b;
      4'd5: e.out = ~a;
      4'd6: begin
        e.out = 16'(ua << amt);
        if (amt != 0) c = a[16-amt];
      end
      4'd7: begin
        if (s) e.out = 16'(sa >>> amt);
        else   e.out = 16'(ua >> amt);
        if (amt != 0) c = a[amt-1];
      end
      4'd8: begin
        if (s) p = longint'(sa) * longint'(sb_);
        else   p = longint'(ua) * longint'(ub);
        e.out = p[15:0]; e.hi = p[31:16];
        if (s) c = (p > 32767) || (p < -32768);
        else   c = p > 65535;
        v = c;
      end
      4'd9: begin
        if (ub == 0) begin
          e.out = 16'hFFFF; e.hi = a; e.dz = 1'b1;
        end else if (s) begin
          if (sa == -32768 && sb_ == -1) begin
            e.out = 16'h8000; e.hi = 16'h0000; v = 1'b1;
          end else begin
            e.out = 16'(sa / sb_); e.hi = 16'(sa % sb_);
          end
        end else begin
          e.out = 16'(ua / ub); e.hi = 16'(ua % ub);
        end
      end
      default: e.il = 1'b1;
    endcase
    e.flags = {e.out == 16'h0000, e.out[15], c, v};
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.O_valid && bus.I_enable) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(bus.O_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out", bus.O_out, mon_e.out);
        chk("out_hi", bus.O_out_hi, mon_e.hi);
        chk("flags", bus.O_flags, mon_e.flags);
        chk("div_zero", bus.O_div_zero, mon_e.dz);
        chk("illegal", bus.O_illegal, mon_e.il);
        pops++;
        pop_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic s,
                       input logic ui, input logic [7:0] imm,
                       input logic [15:0] a, input logic [15:0] rb);
    int g;
    logic [15:0] bv;
    g = 0;
    bus.I_enable = 1'b1;
    while (!bus.O_ready && g < 200) begin
      step();
      g++;
    end
    if (!bus.O_ready) begin
      chk("ready_timeout", 32'(bus.O_ready), 32'd1);
      return;
    end
    bus.I_valid     = 1'b1;
    bus.I_opcode    = op;
    bus.I_signed    = s;
    bus.I_use_imm   = ui;
    bus.I_immediate = imm;
    bus.I_rA        = a;
    bus.I_rB        = rb;
    step();
    acc_edge = cyc;
    bv = rb;
    if (ui) bv = s ? {{8{imm[7]}}, imm} : {8'h00, imm};
    sb.push_back(model(op, s, a, bv));
    bus.I_valid     = 1'b0;
    bus.I_opcode    = 4'($urandom);
    bus.I_signed    = 1'($urandom);
    bus.I_use_imm   = 1'($urandom);
    bus.I_immediate = 8'($urandom);
    bus.I_rA        = 16'($urandom);
    bus.I_rB        = 16'($urandom);
  endtask

  task automatic wait_result(input int n0, input string name);
    int g;
    g = 0;
    while (pops == n0 && g < 200) begin
      step();
      g++;
    end
    chk({name, "_done"}, 32'(pops), 32'(n0 + 1));
  endtask

  task automatic run1(input logic [3:0] op, input logic s,
                      input logic ui, input logic [7:0] imm,
                      input logic [15:0] a, input logic [15:0] rb,
                      input int lat, input string name);
    int n0;
    n0 = pops;
    issue(op, s, ui, imm, a, rb);
    wait_result(n0, name);
    chk({name, "_lat"}, 32'(pop_cyc - acc_edge + 1), 32'(lat));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n0, busy, g;
    logic [3:0] op;
    logic [15:0] ra, rb;
    bus.I_enable = 1'b1;
    bus.I_valid = 1'b0;
    bus.I_opcode = '0;
    bus.I_signed = 1'b0;
    bus.I_use_imm = 1'b0;
    bus.I_immediate = '0;
    bus.I_rA = '0;
    bus.I_rB = '0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(bus.O_ready), 32'd0);
    chk("rst_valid", 32'(bus.O_valid), 32'd0);
    chk("rst_out", bus.O_out, 32'd0);
    chk("rst_flags", bus.O_flags, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(bus.O_ready), 32'd1);

    run1(OP_ADD, 1'b0, 1'b0, 8'h00, 16'hFFFF, 16'h0001, 1, "add_wrap");
    chk("add_wrap_out", bus.O_out, 32'h0000);
    chk("add_wrap_flags", bus.O_flags, 32'b1010);

    run1(OP_SUB, 1'b1, 1'b1, 8'h01, 16'h8000, 16'h1234, 1, "sub_imm");
    chk("sub_imm_out", bus.O_out, 32'h7FFF);
    chk("sub_imm_flags", bus.O_flags, 32'b0001);

    n0 = pops;
    issue(OP_MUL, 1'b1, 1'b0, 8'h00, 16'hFFFE, 16'h0003);
    busy = 0;
    while (!bus.O_ready && busy < 100) begin
      busy++;
      step();
    end
    chk("mul_busy", 32'(busy), 32'd16);
    wait_result(n0, "mul_s");
    chk("mul_s_lat", 32'(pop_cyc - acc_edge + 1), 32'd17);
    chk("mul_s_out", bus.O_out, 32'hFFFA);
    chk("mul_s_hi", bus.O_out_hi, 32'hFFFF);
    chk("mul_s_flags", bus.O_flags, 32'b0100);

    run1(OP_DIV, 1'b0, 1'b0, 8'h00, 16'd100, 16'd7, 17, "div_u");
    chk("div_u_q", bus.O_out, 32'h000E);
    chk("div_u_r", bus.O_out_hi, 32'h0002);

    run1(OP_DIV, 1'b0, 1'b0, 8'h00, 16'h1234, 16'h0000, 1, "div0");
    chk("div0_out", bus.O_out, 32'hFFFF);
    chk("div0_hi", bus.O_out_hi, 32'h1234);
    chk("div0_dz_cleared", 32'(bus.O_div_zero), 32'd0);

    run1(OP_DIV, 1'b1, 1'b0, 8'h00, 16'h8000, 16'hFFFF, 17, "div_ovf");
    chk("div_ovf_flags", bus.O_flags, 32'b0101);

    run1(4'd13, 1'b0, 1'b0, 8'h00, 16'h5555, 16'h1111, 1, "illegal");
    run1(OP_SHL, 1'b0, 1'b0, 8'h00, 16'h8001, 16'h0010, 1, "shl0");

    n0 = pops;
    issue(OP_MUL, 1'b0, 1'b0, 8'h00, 16'h1234, 16'h5678);
    repeat (4) step();
    bus.I_enable = 1'b0;
    repeat (3) step();
    bus.I_enable = 1'b1;
    wait_result(n0, "mul_stall");
    chk("mul_stall_lat", 32'(pop_cyc - acc_edge + 1), 32'd20);

    n0 = pops;
    issue(OP_ADD, 1'b0, 1'b0, 8'h00, 16'h0102, 16'h0304);
    bus.I_enable = 1'b0;
    step();
    step();
    chk("hold_valid", 32'(bus.O_valid), 32'd1);
    chk("hold_pops", 32'(pops), 32'(n0));
    bus.I_enable = 1'b1;
    wait_result(n0, "hold");

    run1(OP_SHR, 1'b1, 1'b0, 8'h00, 16'h8008, 16'h0004, 1, "sra");
    chk("sra_out", bus.O_out, 32'hF800);
    chk("sra_flags", bus.O_flags, 32'b0110);

    n0 = pops;
    issue(OP_DIV, 1'b0, 1'b0, 8'h00, 16'd1000, 16'd3);
    repeat (4) step();
    rst_n = 1'b0;
    sb.delete(sb.size() - 1);
    step();
    chk("abort_out", bus.O_out, 32'd0);
    chk("abort_flags", bus.O_flags, 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    chk("abort_no_valid", 32'(pops), 32'(n0));
    run1(OP_ADD, 1'b0, 1'b0, 8'h00, 16'd2, 16'd3, 1, "post_rst");
    chk("post_rst_out", bus.O_out, 32'h0005);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      issue(op, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            8'($urandom), ra, rb);
      if ($urandom_range(0, 9) == 0) begin
        bus.I_enable = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        bus.I_enable = 1'b1;
      end
    end

    g = 0;
    while (sb.size() != 0 && g < 500) begin
      step();
      g++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
